tipi_pi_bus_master: RTL
=======================

Name: tipi_pi_bus_master

Overview:
- Raspberry Pi-side initiator of the 4-bit TIPI Pi bus; the opposite end of the CPLD's bus slave.
- Generates r_clk and r_nibrst from one system clock.
- Each transaction reads TC and TD from the CPLD, then writes RC and RD into it, one nibble per slot.
- Used in the Pi-side FPGA bridge and as the bus-functional driver for CPLD verification.

Parameters:
CLK_DIV, 4, clk cycles per r_clk phase (low and high phase each); legal range >= 2
RST_HOLD, 2, clk cycles r_nibrst is held high, and then low, before the first slot; legal range >= 1

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request one transaction; sampled only in IDLE
wr_rc  input  [0:7]  value to write to RC; captured on accepted start
wr_rd  input  [0:7]  value to write to RD; captured on accepted start
rd_tc  output  [0:7]  TC value read in last completed transaction
rd_td  output  [0:7]  TD value read in last completed transaction
busy  output  1  high from accepted start until the done cycle, exclusive
done  output  1  one-cycle pulse when the transaction completes
r_clk  output  1  Pi bus clock to CPLD
r_nibrst  output  1  Pi bus sequence reset to CPLD, active high
r_nib_out  output  [0:3]  nibble driven toward CPLD
r_nib_oe  output  1  pad output enable for r_nib_out
r_nib_in  input  [0:3]  nibble from the r_nib pads

Behaviour:
- Reset values: r_clk=0, r_nibrst=1, r_nib_out=0, r_nib_oe=0, busy=0, done=0, rd_tc=0, rd_td=0, FSM=IDLE. Reset mid-transaction aborts immediately; rd_tc/rd_td return to 0.
- FSM states: IDLE, RST_HI, RST_LO, SLOT_LOW, SLOT_HIGH, DONE.
- IDLE:
  - r_nibrst=0 after the first transaction; it stays 1 only out of reset.
  - start=1 captures wr_rc/wr_rd, sets busy, and moves to RST_HI.
- RST_HI: r_nibrst=1 for RST_HOLD cycles, then RST_LO.
- RST_LO: r_nibrst=0 for RST_HOLD cycles, then SLOT_LOW with slot=0.
- Slot map, 8 slots, high nibble ([0:3] = bits 0..3) first:
  - 0,1 read TC
  - 2,3 read TD
  - 4,5 write RC
  - 6,7 write RD
- SLOT_LOW: r_clk=0 for CLK_DIV cycles.
  - Read slot: on the last cycle of the phase, register r_nib_in into the shadow nibble for that slot.
  - Write slot: r_nib_out carries the slot's nibble for the whole low and high phase.
- SLOT_HIGH: r_clk=1 for CLK_DIV cycles.
  - The CPLD advances its sequence and latches write nibbles on the r_clk rising edge.
  - After the phase: if slot<7, increment slot and go to SLOT_LOW; else go to DONE.
- r_nib_oe:
  - 1 from the first cycle of slot 4 SLOT_LOW through the last cycle of slot 7 SLOT_HIGH; 0 otherwise.
  - Never 1 in read slots or in RST states.
- DONE, one cycle:
  - done=1 and busy=0.
  - rd_tc/rd_td updated from the shadow registers; they are otherwise stable through a transaction.
  - r_nib_oe=0, r_clk=0; next state IDLE.
- Latency:
  - Accepted start at cycle N gives done at cycle N + 1 + 2*RST_HOLD + 16*CLK_DIV.
  - Defaults: N+69.
- Boundary conditions:
  - start while busy or in DONE is ignored; no queuing.
  - start in the cycle after DONE is accepted normally.
- Widths: slot counter 3 bits, phase counter sized for CLK_DIV-1. No wrap mid-transaction; slot 7 terminates.

Test Plan:
- Defaults, behavioural CPLD model with TC=8'hA5, TD=8'h3C; start with wr_rc=8'h12, wr_rd=8'hF0 -> done exactly 69 cycles after start, rd_tc=8'hA5, rd_td=8'h3C, model RC=8'h12, RD=8'hF0, exactly 8 r_clk rising edges.
- Pin trace, same run -> r_nibrst high 2 cycles then low 2; r_nib_out sequence 1,2,F,0 only while r_nib_oe=1; r_nib_oe=0 in all read slots.
- start pulsed at cycles +5 and +40 of a busy transaction -> ignored: one done pulse only, captured wr_rc/wr_rd unchanged.
- Async reset asserted during slot 5 -> same cycle: r_nibrst=1, r_nib_oe=0, r_clk=0, busy=0, rd_tc=rd_td=0. Next start completes a clean transaction with correct data.
- Back-to-back: start held high continuously -> done pulses every 70 cycles; each transaction re-pulses r_nibrst.
- CLK_DIV=2, RST_HOLD=1 -> done 35 cycles after start, r_clk period 4 cycles, data as in the first scenario.

Source files
------------

// File: rtl/tipi_pi_bus_master_if.sv
// Host-side handshake and pad-side Pi bus signals of the TIPI Pi bus master.
interface tipi_pi_bus_master_if;
  logic       start;
  logic [0:7] wr_rc;
  logic [0:7] wr_rd;
  logic [0:7] rd_tc;
  logic [0:7] rd_td;
  logic       busy;
  logic       done;
  logic       r_clk;
  logic       r_nibrst;
  logic [0:3] r_nib_out;
  logic       r_nib_oe;
  logic [0:3] r_nib_in;

  modport master (
    input  start, wr_rc, wr_rd, r_nib_in,
    output rd_tc, rd_td, busy, done, r_clk, r_nibrst, r_nib_out, r_nib_oe
  );

  modport slave (
    output start, wr_rc, wr_rd, r_nib_in,
    input  rd_tc, rd_td, busy, done, r_clk, r_nibrst, r_nib_out, r_nib_oe
  );
endinterface

// File: rtl/tipi_pi_bus_master.sv
// Pi-side TIPI bus initiator: per start, reads TC/TD then writes RC/RD, one nibble per r_clk slot.
module tipi_pi_bus_master #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned RST_HOLD = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  tipi_pi_bus_master_if.master bus
);
  localparam int unsigned CNT_MAX = (CLK_DIV > RST_HOLD) ? CLK_DIV : RST_HOLD;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned SLOT_W  = 3;
  localparam logic [CNT_W-1:0]  DIV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(RST_HOLD - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(7);

  typedef enum logic [2:0] {
    IDLE, RST_HI, RST_LO, SLOT_LOW, SLOT_HIGH, DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic [0:7]         rc_q, rc_d, rd_q, rd_d;
  logic [0:7]         tc_sh_q, tc_sh_d, td_sh_q, td_sh_d;
  logic [0:7]         rd_tc_q, rd_tc_d, rd_td_q, rd_td_d;
  logic               r_clk_q, r_clk_d;
  logic               r_nibrst_q, r_nibrst_d;
  logic               r_nib_oe_q, r_nib_oe_d;
  logic [0:3]         r_nib_out_q, r_nib_out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [0:3]         wr_nib;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      slot_q      <= '0;
      rc_q        <= '0;
      rd_q        <= '0;
      tc_sh_q     <= '0;
      td_sh_q     <= '0;
      rd_tc_q     <= '0;
      rd_td_q     <= '0;
      r_clk_q     <= 1'b0;
      r_nibrst_q  <= 1'b1;
      r_nib_oe_q  <= 1'b0;
      r_nib_out_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      slot_q      <= slot_d;
      rc_q        <= rc_d;
      rd_q        <= rd_d;
      tc_sh_q     <= tc_sh_d;
      td_sh_q     <= td_sh_d;
      rd_tc_q     <= rd_tc_d;
      rd_td_q     <= rd_td_d;
      r_clk_q     <= r_clk_d;
      r_nibrst_q  <= r_nibrst_d;
      r_nib_oe_q  <= r_nib_oe_d;
      r_nib_out_q <= r_nib_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Sequencer: reset pulse, then 8 slots of CLK_DIV low + CLK_DIV high cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    rc_d    = rc_q;
    rd_d    = rd_q;
    tc_sh_d = tc_sh_q;
    td_sh_d = td_sh_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RST_HI;
          cnt_d   = '0;
          rc_d    = bus.wr_rc;
          rd_d    = bus.wr_rd;
        end
      end
      RST_HI: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = RST_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RST_LO: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = SLOT_LOW;
          cnt_d   = '0;
          slot_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SLOT_LOW: begin
        if (cnt_q == DIV_LAST) begin
          state_d = SLOT_HIGH;
          cnt_d   = '0;
          // Read slots sample the pads on the last low cycle, just before r_clk rises.
          if (!slot_q[2]) begin
            unique case (slot_q[1:0])
              2'd0: tc_sh_d[0:3] = bus.r_nib_in;
              2'd1: tc_sh_d[4:7] = bus.r_nib_in;
              2'd2: td_sh_d[0:3] = bus.r_nib_in;
              2'd3: td_sh_d[4:7] = bus.r_nib_in;
            endcase
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SLOT_HIGH: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (slot_q == SLOT_LAST) begin
            state_d = DONE;
          end else begin
            state_d = SLOT_LOW;
            slot_d  = slot_q + SLOT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so each register lines up with its state.
  always_comb begin
    wr_nib = '0;
    unique case (slot_d[1:0])
      2'd0: wr_nib = rc_q[0:3];
      2'd1: wr_nib = rc_q[4:7];
      2'd2: wr_nib = rd_q[0:3];
      2'd3: wr_nib = rd_q[4:7];
    endcase
    r_clk_d     = (state_d == SLOT_HIGH);
    r_nib_oe_d  = ((state_d == SLOT_LOW) || (state_d == SLOT_HIGH)) && slot_d[2];
    r_nib_out_d = r_nib_oe_d ? wr_nib : '0;
    busy_d      = (state_d != IDLE) && (state_d != DONE);
    done_d      = (state_d == DONE);
    rd_tc_d     = done_d ? tc_sh_q : rd_tc_q;
    rd_td_d     = done_d ? td_sh_q : rd_td_q;
    // r_nibrst keeps its reset value in IDLE until the first transaction clears it.
    r_nibrst_d  = r_nibrst_q;
    if (state_d == RST_HI) begin
      r_nibrst_d = 1'b1;
    end else if (state_d != IDLE) begin
      r_nibrst_d = 1'b0;
    end
  end

  assign bus.rd_tc     = rd_tc_q;
  assign bus.rd_td     = rd_td_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.r_clk     = r_clk_q;
  assign bus.r_nibrst  = r_nibrst_q;
  assign bus.r_nib_out = r_nib_out_q;
  assign bus.r_nib_oe  = r_nib_oe_q;
endmodule
